// File: rtl/cp0_access_ctrl.sv
// Single-port CP0 register file sequencer: arbitrates exception entry, ERET and
// pipeline MFC0/MTC0, running exception/ERET as read-modify-write sequences.
module cp0_access_ctrl #(
    parameter logic [5:0]  STATUS_NUM = 6'd15,
    parameter logic [5:0]  CAUSE_NUM  = 6'd16,
    parameter logic [5:0]  EPC_NUM    = 6'd17,
    parameter logic [5:0]  BADVA_NUM  = 6'd8,
    parameter int unsigned EXL_BIT    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_valid,
    output logic        exc_ready,
    input  logic [4:0]  exc_code,
    input  logic        exc_bd,
    input  logic [31:0] exc_epc,
    input  logic        exc_has_badva,
    input  logic [31:0] exc_badva,
    output logic        exc_done,
    input  logic        eret_valid,
    output logic        eret_ready,
    output logic        eret_done,
    input  logic        pipe_valid,
    output logic        pipe_ready,
    input  logic        pipe_we,
    input  logic [5:0]  pipe_reg_num,
    input  logic        pipe_reg_ok,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_rsp_valid,
    output logic [31:0] pipe_rdata,
    output logic        rf_en,
    output logic        rf_we,
    output logic [5:0]  rf_addr,
    output logic [31:0] rf_wdata,
    input  logic [31:0] rf_rdata,
    output logic        busy
);

    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 5;
    localparam int unsigned KW  = 26;
    localparam logic [DW-1:0] EXL_MASK = DW'(1) << EXL_BIT;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        X_RDC = 3'd1,
        X_WRS = 3'd2,
        X_WRC = 3'd3,
        X_WRE = 3'd4,
        X_WRB = 3'd5,
        E_WRS = 3'd6,
        P_RSP = 3'd7
    } state_t;

    state_t          state;
    logic [CW-1:0]   x_code;
    logic            x_bd;
    logic [DW-1:0]   x_epc;
    logic            x_has_badva;
    logic [DW-1:0]   x_badva;
    logic [DW-1:0]   old_status;
    logic [KW-1:0]   cause_keep;   // Cause[30:7] and Cause[1:0], preserved on exception entry
    logic            p_rd;

    logic            old_exl;
    assign old_exl = old_status[EXL_BIT];

    // Sequencer state and captured request data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            x_code      <= '0;
            x_bd        <= 1'b0;
            x_epc       <= '0;
            x_has_badva <= 1'b0;
            x_badva     <= '0;
            old_status  <= '0;
            cause_keep  <= '0;
            p_rd        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (exc_valid) begin
                        x_code      <= exc_code;
                        x_bd        <= exc_bd;
                        x_epc       <= exc_epc;
                        x_has_badva <= exc_has_badva;
                        x_badva     <= exc_badva;
                        state       <= X_RDC;
                    end else if (eret_valid) begin
                        state <= E_WRS;
                    end else if (pipe_valid) begin
                        p_rd  <= !pipe_we && pipe_reg_ok;
                        state <= P_RSP;
                    end
                end
                X_RDC: begin
                    old_status <= rf_rdata;
                    state      <= X_WRS;
                end
                X_WRS: begin
                    cause_keep <= {rf_rdata[30:7], rf_rdata[1:0]};
                    state      <= X_WRC;
                end
                X_WRC: begin
                    if (!old_exl)         state <= X_WRE;
                    else if (x_has_badva) state <= X_WRB;
                    else                  state <= IDLE;
                end
                X_WRE:   state <= x_has_badva ? X_WRB : IDLE;
                X_WRB:   state <= IDLE;
                E_WRS:   state <= IDLE;
                P_RSP:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Port handshakes and regfile strobes decoded from state; all quiet while in reset
    always_comb begin
        exc_ready      = 1'b0;
        eret_ready     = 1'b0;
        pipe_ready     = 1'b0;
        exc_done       = 1'b0;
        eret_done      = 1'b0;
        pipe_rsp_valid = 1'b0;
        pipe_rdata     = '0;
        rf_en          = 1'b0;
        rf_we          = 1'b0;
        rf_addr        = '0;
        rf_wdata       = '0;
        busy           = 1'b0;
        if (rst_n) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (exc_valid) begin
                        exc_ready = 1'b1;
                        rf_en     = 1'b1;
                        rf_addr   = STATUS_NUM;
                    end else if (eret_valid) begin
                        eret_ready = 1'b1;
                        rf_en      = 1'b1;
                        rf_addr    = STATUS_NUM;
                    end else if (pipe_valid) begin
                        pipe_ready = 1'b1;
                        if (pipe_reg_ok) begin
                            rf_en    = 1'b1;
                            rf_we    = pipe_we;
                            rf_addr  = pipe_reg_num;
                            rf_wdata = pipe_we ? pipe_wdata : '0;
                        end
                    end
                end
                X_RDC: begin
                    rf_en   = 1'b1;
                    rf_addr = CAUSE_NUM;
                end
                X_WRS: begin
                    rf_en    = 1'b1;
                    rf_we    = 1'b1;
                    rf_addr  = STATUS_NUM;
                    rf_wdata = old_status | EXL_MASK;
                end
                X_WRC: begin
                    rf_en    = 1'b1;
                    rf_we    = 1'b1;
                    rf_addr  = CAUSE_NUM;
                    rf_wdata = {x_bd, cause_keep[KW-1:2], x_code, cause_keep[1:0]};
                    exc_done = old_exl && !x_has_badva;
                end
                X_WRE: begin
                    rf_en    = 1'b1;
                    rf_we    = 1'b1;
                    rf_addr  = EPC_NUM;
                    rf_wdata = x_epc;
                    exc_done = !x_has_badva;
                end
                X_WRB: begin
                    rf_en    = 1'b1;
                    rf_we    = 1'b1;
                    rf_addr  = BADVA_NUM;
                    rf_wdata = x_badva;
                    exc_done = 1'b1;
                end
                E_WRS: begin
                    rf_en     = 1'b1;
                    rf_we     = 1'b1;
                    rf_addr   = STATUS_NUM;
                    rf_wdata  = rf_rdata & ~EXL_MASK;
                    eret_done = 1'b1;
                end
                P_RSP: begin
                    pipe_rsp_valid = 1'b1;
                    pipe_rdata     = p_rd ? rf_rdata : '0;
                end
                default: ;
            endcase
        end
    end

endmodule
